// File: rtl/comparator_search_ctrl_if.sv
// comparator_search_ctrl_if
// Groups the request/status handshake and the comparator operand/flag wires
// of the binary-search controller.
//   start                  : one-cycle search request (initiator -> controller)
//   probe                  : operand driven to comparator input b
//   cmp_gt/cmp_lt/cmp_eq   : comparator flags (target vs probe)
//   busy/done/found/result : search status and outcome
//   err                    : comparator flag protocol violation
// Modports: slave = the controller, master = its environment
// (the requester plus the comparator).
interface comparator_search_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] probe;
  logic             cmp_gt;
  logic             cmp_lt;
  logic             cmp_eq;
  logic             busy;
  logic             done;
  logic             found;
  logic [WIDTH-1:0] result;
  logic             err;

  modport slave (
    input  start, cmp_gt, cmp_lt, cmp_eq,
    output probe, busy, done, found, result, err
  );

  modport master (
    output start, cmp_gt, cmp_lt, cmp_eq,
    input  probe, busy, done, found, result, err
  );
endinterface

// File: rtl/comparator_search_ctrl.sv
// comparator_search_ctrl
// Initiator side of a magnitude-comparator interface. It drives a probe
// operand into an external combinational comparator whose other operand
// holds a hidden target, and binary-searches for that target over
// 0 .. 2^WIDTH-1 using the gt/lt/eq flags. It reports the matched value,
// or reports not-found.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : comparator_search_ctrl_if.slave (start, probe, cmp_gt/lt/eq,
//            busy, done, found, result, err)
// Optional feature macro: CMP_ONEHOT_CHECK_EN
//   Defined   : a flag set that is not exactly one-hot during SEARCH sets
//               err and ends the search as not-found.
//   Undefined : err is constant 0 and flags resolve with eq > gt > lt
//               priority; no flag set is treated as lt.
module comparator_search_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  comparator_search_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] FIRST   = MAX_VAL >> 1;
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO    = '0;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] probe_q, probe_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             found_q, found_d;
  logic             err_q, err_d;

  // Decoded comparator outcome for the current probe
  logic             take_eq, take_gt, bad_flags;
  logic [WIDTH-1:0] next_lo, next_hi;

  // lo + ((hi - lo) >> 1) evaluated one bit wider so the sum cannot wrap.
  // Only called with l <= h.
  function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH-1:0] l,
                                                input logic [WIDTH-1:0] h);
    logic [WIDTH:0] span;
    logic [WIDTH:0] sum;
    span = {1'b0, h} - {1'b0, l};
    sum  = {1'b0, l} + (span >> 1);
    return sum[WIDTH-1:0];
  endfunction

`ifdef CMP_ONEHOT_CHECK_EN
  always_comb begin
    bad_flags = 1'b1;
    take_eq   = 1'b0;
    take_gt   = 1'b0;
    case ({bus.cmp_eq, bus.cmp_gt, bus.cmp_lt})
      3'b100:  begin bad_flags = 1'b0; take_eq = 1'b1; end
      3'b010:  begin bad_flags = 1'b0; take_gt = 1'b1; end
      3'b001:  bad_flags = 1'b0;
      default: bad_flags = 1'b1;
    endcase
  end
`else
  // eq wins over gt, gt over lt; an empty flag set falls through to lt
  always_comb begin
    bad_flags = 1'b0;
    take_eq   = 1'b0;
    take_gt   = 1'b0;
    casez ({bus.cmp_eq, bus.cmp_gt, bus.cmp_lt})
      3'b1??:  take_eq = 1'b1;
      3'b01?:  take_gt = 1'b1;
      3'b001:  take_gt = 1'b0;
      default: take_gt = 1'b0;
    endcase
  end
`endif

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    probe_d  = probe_q;
    result_d = result_q;
    found_d  = found_q;
    err_d    = err_q;
    next_lo  = probe_q + ONE;
    next_hi  = probe_q - ONE;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          lo_d     = ZERO;
          hi_d     = MAX_VAL;
          probe_d  = FIRST;
          found_d  = 1'b0;
          result_d = ZERO;
          err_d    = 1'b0;
          state_d  = SEARCH;
        end
      end

      SEARCH: begin
        if (bad_flags) begin
          err_d   = 1'b1;
          found_d = 1'b0;
          state_d = DONE;
        end else if (take_eq) begin
          result_d = probe_q;
          found_d  = 1'b1;
          state_d  = DONE;
        end else if (take_gt) begin
          // Target lies above the probe; the guard keeps probe+1 from wrapping
          if (probe_q == MAX_VAL) begin
            found_d = 1'b0;
            state_d = DONE;
          end else begin
            lo_d = next_lo;
            if (next_lo > hi_q) begin
              found_d = 1'b0;
              state_d = DONE;
            end else begin
              probe_d = midpoint(next_lo, hi_q);
            end
          end
        end else begin
          // Target lies below the probe; the guard keeps probe-1 from wrapping
          if (probe_q == ZERO) begin
            found_d = 1'b0;
            state_d = DONE;
          end else begin
            hi_d = next_hi;
            if (lo_q > next_hi) begin
              found_d = 1'b0;
              state_d = DONE;
            end else begin
              probe_d = midpoint(lo_q, next_hi);
            end
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      probe_q  <= '0;
      result_q <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      probe_q  <= probe_d;
      result_q <= result_d;
      found_q  <= found_d;
      err_q    <= err_d;
    end
  end

  assign bus.probe  = probe_q;
  assign bus.result = result_q;
  assign bus.found  = found_q;
  assign bus.err    = err_q;
  assign bus.busy   = (state_q == SEARCH);
  assign bus.done   = (state_q == DONE);

endmodule

// File: tb/tb_comparator_search_ctrl.sv
// tb_comparator_search_ctrl
// Directed bench for comparator_search_ctrl at WIDTH=4. A behavioural
// comparator stub answers for a chosen target, or forces fixed flag patterns.
module tb_comparator_search_ctrl;
  logic clk;
  logic rst_n;
  logic [3:0] target;
  int mode;  // 0 normal compare, 1 always gt, 2 always lt, 3 gt+eq together

  int pass_cnt;
  int tot_cnt;

  // Per-search observations collected by do_search
  logic [31:0] seq_pk;
  int busy_cnt;
  int done_cnt;
  int done_c;

  comparator_search_ctrl_if #(.WIDTH(4)) bus ();

  comparator_search_ctrl #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    bus.cmp_gt = 1'b0;
    bus.cmp_lt = 1'b0;
    bus.cmp_eq = 1'b0;
    case (mode)
      0: begin
        bus.cmp_gt = (target > bus.probe);
        bus.cmp_lt = (target < bus.probe);
        bus.cmp_eq = (target == bus.probe);
      end
      1: bus.cmp_gt = 1'b1;
      2: bus.cmp_lt = 1'b1;
      3: begin bus.cmp_gt = 1'b1; bus.cmp_eq = 1'b1; end
      default: bus.cmp_eq = 1'b0;
    endcase
  end

  // Issues one start, then watches a fixed 10-cycle window, packing each
  // busy-cycle probe into seq_pk (first probe most significant).
  // pulse[c] drives start during window cycle c.
  task automatic do_search(input logic [3:0] tgt, input int md, input logic [9:0] pulse);
    target = tgt; mode = md;
    seq_pk = '0; busy_cnt = 0; done_cnt = 0; done_c = -1;
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 10; c++) begin
      bus.start = pulse[c];
      if (bus.busy) begin seq_pk = (seq_pk << 4) | {28'd0, bus.probe}; busy_cnt++; end
      if (bus.done) begin done_cnt++; if (done_c < 0) done_c = c; end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.start = 1'b0; target = 4'd0; mode = 0;
    #2;
    tot_cnt++; if (bus.probe !== 4'd0) $display("FAIL reset_probe: got %h want 0", bus.probe); else pass_cnt++;
    tot_cnt++; if (bus.result !== 4'd0) $display("FAIL reset_result: got %h want 0", bus.result); else pass_cnt++;
    tot_cnt++; if ({bus.found, bus.done, bus.busy, bus.err} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000", {bus.found, bus.done, bus.busy, bus.err}); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_target7();
    do_search(4'd7, 0, 10'd0);
    tot_cnt++; if (seq_pk !== 32'h7) $display("FAIL t7_seq: got %h want 7", seq_pk); else pass_cnt++;
    tot_cnt++; if (done_c !== 1) $display("FAIL t7_latency: got %0d want 1", done_c); else pass_cnt++;
    tot_cnt++; if (busy_cnt !== 1) $display("FAIL t7_busy: got %0d want 1", busy_cnt); else pass_cnt++;
    tot_cnt++; if (done_cnt !== 1) $display("FAIL t7_done_cnt: got %0d want 1", done_cnt); else pass_cnt++;
    tot_cnt++; if ({bus.found, bus.result, bus.err} !== {1'b1, 4'd7, 1'b0})
      $display("FAIL t7_outcome: got found=%b result=%h err=%b want 1 7 0", bus.found, bus.result, bus.err); else pass_cnt++;
  endtask

  task automatic test_target0();
    do_search(4'd0, 0, 10'd0);
    tot_cnt++; if (seq_pk !== 32'h7310) $display("FAIL t0_seq: got %h want 7310", seq_pk); else pass_cnt++;
    tot_cnt++; if (done_c !== 4) $display("FAIL t0_latency: got %0d want 4", done_c); else pass_cnt++;
    tot_cnt++; if ({bus.found, bus.result} !== {1'b1, 4'd0})
      $display("FAIL t0_outcome: got found=%b result=%h want 1 0", bus.found, bus.result); else pass_cnt++;
  endtask

  task automatic test_target15();
    do_search(4'd15, 0, 10'd0);
    tot_cnt++; if (seq_pk !== 32'h7BDEF) $display("FAIL t15_seq: got %h want 7bdef", seq_pk); else pass_cnt++;
    tot_cnt++; if (done_c !== 5) $display("FAIL t15_latency: got %0d want 5", done_c); else pass_cnt++;
    tot_cnt++; if ({bus.found, bus.result} !== {1'b1, 4'd15})
      $display("FAIL t15_outcome: got found=%b result=%h want 1 f", bus.found, bus.result); else pass_cnt++;
  endtask

  task automatic test_stuck_flags();
    do_search(4'd0, 1, 10'd0);
    tot_cnt++; if (seq_pk !== 32'h7BDEF) $display("FAIL gt_seq: got %h want 7bdef", seq_pk); else pass_cnt++;
    tot_cnt++; if ({done_cnt, bus.found} !== {32'd1, 1'b0})
      $display("FAIL gt_outcome: got done_cnt=%0d found=%b want 1 0", done_cnt, bus.found); else pass_cnt++;
    do_search(4'd0, 2, 10'd0);
    tot_cnt++; if (seq_pk !== 32'h7310) $display("FAIL lt_seq: got %h want 7310", seq_pk); else pass_cnt++;
    tot_cnt++; if ({done_cnt, bus.found, bus.result} !== {32'd1, 1'b0, 4'd0})
      $display("FAIL lt_outcome: got done_cnt=%0d found=%b result=%h want 1 0 0", done_cnt, bus.found, bus.result); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    // start re-pulsed in SEARCH (cycle 1) and in the DONE cycle (cycle 4)
    do_search(4'd0, 0, 10'b00000_10010);
    tot_cnt++; if (seq_pk !== 32'h7310) $display("FAIL b2b_seq: got %h want 7310", seq_pk); else pass_cnt++;
    tot_cnt++; if (done_cnt !== 1) $display("FAIL b2b_done_cnt: got %0d want 1", done_cnt); else pass_cnt++;
    tot_cnt++; if (busy_cnt !== 4) $display("FAIL b2b_busy: got %0d want 4", busy_cnt); else pass_cnt++;
    tot_cnt++; if ({bus.probe, bus.found, bus.result} !== {4'd0, 1'b1, 4'd0})
      $display("FAIL b2b_hold: got probe=%h found=%b result=%h want 0 1 0", bus.probe, bus.found, bus.result); else pass_cnt++;
  endtask

  task automatic test_reset_mid_search();
    int seen_done;
    seen_done = 0;
    target = 4'd15; mode = 0;
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    @(posedge clk); #1;
    tot_cnt++; if ({bus.busy, bus.probe} !== {1'b1, 4'd11})
      $display("FAIL mid_pre: got busy=%b probe=%h want 1 b", bus.busy, bus.probe); else pass_cnt++;
    #2; rst_n = 1'b0; #1;
    tot_cnt++; if ({bus.probe, bus.result, bus.found, bus.done, bus.busy, bus.err} !== 12'd0)
      $display("FAIL mid_async: got probe=%h result=%h f/d/b/e=%b want all 0", bus.probe, bus.result,
               {bus.found, bus.done, bus.busy, bus.err}); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.done) seen_done++;
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    if (bus.done) seen_done++;
    tot_cnt++; if (seen_done !== 0) $display("FAIL mid_no_done: got %0d done cycles want 0", seen_done); else pass_cnt++;
    do_search(4'd9, 0, 10'd0);
    tot_cnt++; if (seq_pk !== 32'h7B9) $display("FAIL t9_seq: got %h want 7b9", seq_pk); else pass_cnt++;
    tot_cnt++; if ({done_cnt, bus.found, bus.result} !== {32'd1, 1'b1, 4'd9})
      $display("FAIL t9_outcome: got done_cnt=%0d found=%b result=%h want 1 1 9", done_cnt, bus.found, bus.result); else pass_cnt++;
  endtask

  task automatic test_onehot();
    do_search(4'd7, 3, 10'd0);
    tot_cnt++; if (done_cnt !== 1) $display("FAIL oh_done_cnt: got %0d want 1", done_cnt); else pass_cnt++;
`ifdef CMP_ONEHOT_CHECK_EN
    tot_cnt++; if ({bus.err, bus.found} !== 2'b10)
      $display("FAIL oh_err: got err=%b found=%b want 1 0", bus.err, bus.found); else pass_cnt++;
    do_search(4'd7, 0, 10'd0);
    tot_cnt++; if ({bus.err, bus.found, bus.result} !== {1'b0, 1'b1, 4'd7})
      $display("FAIL oh_clear: got err=%b found=%b result=%h want 0 1 7", bus.err, bus.found, bus.result); else pass_cnt++;
`else
    tot_cnt++; if ({bus.err, bus.found, bus.result} !== {1'b0, 1'b1, 4'd7})
      $display("FAIL oh_priority: got err=%b found=%b result=%h want 0 1 7", bus.err, bus.found, bus.result); else pass_cnt++;
`endif
  endtask

  initial begin
    pass_cnt = 0;
    tot_cnt = 0;
    bus.start = 1'b0;
    test_reset();
    test_target7();
    test_target0();
    test_target15();
    test_stuck_flags();
    test_back_to_back();
    test_reset_mid_search();
    test_onehot();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
